respondedor_memoria: RTL and testbench

RESPONDEDOR_MEMORIA -- requirements
Module: respondedor_memoria

---
 rtl/respondedor_memoria_pkg.sv | 19 +
 rtl/respondedor_memoria_banco.sv | 32 +++
 rtl/respondedor_memoria.sv | 161 ++++++++++++++++
 tb/tb_respondedor_memoria.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/respondedor_memoria_pkg.sv
// respondedor_memoria_pkg
// Shared processor definitions for the data-memory responder: word width,
// wait-counter width, responder state encoding and a small alignment helper.
// No ports; imported by respondedor_memoria and banco_memoria_dados.
package respondedor_memoria_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // A word access must have both byte-offset bits clear.
  function automatic logic is_misaligned(input logic [WORD_W-1:0] a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/respondedor_memoria_banco.sv
// banco_memoria_dados
// Single-port word storage for the memory responder. The write is synchronous
// and the read is combinational from the same index. Contents are not reset.
// Ports:
//   clk    - clock, write on rising edge
//   we     - write enable for this edge
//   index  - word index (read and write)
//   wdata  - word to write
//   rdata  - word currently stored at index
module banco_memoria_dados
  import respondedor_memoria_pkg::*;
#(
  parameter int DEPTH_WORDS = 64
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] index,
  input  logic [WORD_W-1:0]              wdata,
  output logic [WORD_W-1:0]              rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[index] <= wdata;
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/respondedor_memoria.sv
// respondedor_memoria
// Data-memory responder for the processor's memory stage. A request accepted
// in IDLE is held for LATENCY wait cycles and then answered with a one-cycle
// ack. Stores commit on the edge that raises ack; loads return the stored word.
// Misaligned accesses answer with err=1, rdata=0 and no write.
// Build option: define RESP_BOUNDS_CHECK_EN to also flag addresses above the
// storage range as errors; otherwise upper address bits are ignored (wrap).
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   req, we      - request strobe and store(1)/load(0) select
//   addr, wdata  - byte address and store data
//   rdata        - load data, zero unless ack
//   ack          - one-cycle response pulse
//   busy         - transaction in flight, through the ack cycle
//   err          - error flag, zero unless ack
module respondedor_memoria
  import respondedor_memoria_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              we_q;
  logic [WORD_W-1:0] rdata_q;
  logic              err_q;

  logic [WORD_W-1:0] eff_addr;
  logic [WORD_W-1:0] eff_wdata;
  logic              eff_we;
  logic              enter_resp;
  logic              err_now;
  logic              out_of_range;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;

  // With zero latency the response is produced straight from the inputs of
  // the accepting cycle, so the effective transaction comes from the ports in
  // IDLE and from the captured copy otherwise.
  always_comb begin
    eff_addr  = addr_q;
    eff_wdata = wdata_q;
    eff_we    = we_q;
    if (state == ST_IDLE) begin
      eff_addr  = addr;
      eff_wdata = wdata;
      eff_we    = we;
    end
  end

  // The edge entering RESP is the edge that raises ack: the store commits and
  // the response registers load on that same edge.
  always_comb begin
    enter_resp = 1'b0;
    if (state == ST_IDLE && req && LATENCY == 0) begin
      enter_resp = 1'b1;
    end else if (state == ST_WAIT && cnt == CNT_W'(1)) begin
      enter_resp = 1'b1;
    end
  end

`ifdef RESP_BOUNDS_CHECK_EN
  assign out_of_range = |eff_addr[WORD_W-1:AW+2];
`else
  logic unused_upper;
  assign unused_upper = ^eff_addr[WORD_W-1:AW+2];
  assign out_of_range = 1'b0;
`endif

  assign err_now = is_misaligned(eff_addr) || out_of_range;
  assign mem_we  = enter_resp && !reset && eff_we && !err_now;

  banco_memoria_dados #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_banco (
    .clk   (clk),
    .we    (mem_we),
    .index (eff_addr[AW+1:2]),
    .wdata (eff_wdata),
    .rdata (mem_rdata)
  );

  // Transaction capture; these only matter while busy, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && req) begin
      addr_q  <= addr;
      wdata_q <= wdata;
      we_q    <= we;
    end
  end

  // Control FSM and response registers. Response registers default to zero so
  // rdata and err are only non-zero during the RESP (ack) cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= '0;
      err_q   <= 1'b0;
      if (enter_resp) begin
        err_q <= err_now;
        if (!eff_we && !err_now) begin
          rdata_q <= mem_rdata;
        end
      end
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (LATENCY == 0) begin
              state <= ST_RESP;
              cnt   <= '0;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_W'(LATENCY);
            end
          end
        end
        ST_WAIT: begin
          if (cnt == CNT_W'(1)) begin
            state <= ST_RESP;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign ack   = (state == ST_RESP);
  assign busy  = (state != ST_IDLE);
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_respondedor_memoria.sv
// tb_respondedor_memoria
// Self-checking bench for respondedor_memoria: one instance with LATENCY=2 and
// one with LATENCY=0, both DEPTH_WORDS=64. Expected responses come from a
// behavioural memory model and are queued when a request is driven.
module tb_respondedor_memoria;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        ack, busy, err;

  logic        req0, we0;
  logic [31:0] addr0, wdata0;
  logic [31:0] rdata0;
  logic        ack0, busy0, err0;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_mem [64];
  logic [32:0] exp_q [$];

  respondedor_memoria #(.DEPTH_WORDS(64), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .busy(busy), .err(err)
  );

  respondedor_memoria #(.DEPTH_WORDS(64), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0),
    .wdata(wdata0), .rdata(rdata0), .ack(ack0), .busy(busy0), .err(err0)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Model: computes the response of one access and updates the model memory.
  function automatic logic [32:0] model_access(input logic w, input logic [31:0] a,
                                               input logic [31:0] d);
    logic        e;
    logic [31:0] r;
    logic [5:0]  idx;
    e = (a[1:0] != 2'b00);
`ifdef RESP_BOUNDS_CHECK_EN
    e = e || (a[31:8] != 24'd0);
`endif
    idx = a[7:2];
    r   = 32'd0;
    if (!e) begin
      if (w) model_mem[idx] = d;
      else   r = model_mem[idx];
    end
    return {e, r};
  endfunction

  task automatic popCompare(input string tag);
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      checkOutput({tag, "_err"}, {31'd0, err}, {31'd0, e[32]});
      checkOutput({tag, "_rdata"}, rdata, e[31:0]);
    end
  endtask

  // One access on the LATENCY=2 instance, with latency and idle checks.
  task automatic applyStimulus(input string tag, input logic w,
                               input logic [31:0] a, input logic [31:0] d);
    int n;
    exp_q.push_back(model_access(w, a, d));
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
    n = 1;
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
    while (!ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_ack_seen"}, {31'd0, ack}, 32'd1);
    checkOutput({tag, "_latency"}, n, 32'd3);
    if (ack) popCompare(tag);
    else void'(exp_q.pop_front());
    @(negedge clk);
    checkOutput({tag, "_idle_ack"}, {31'd0, ack}, 32'd0);
    checkOutput({tag, "_idle_rd"}, rdata, 32'd0);
    checkOutput({tag, "_idle_err"}, {31'd0, err}, 32'd0);
    checkOutput({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int acks;
    int prev_ack;
    int adjacent;
    reset = 1'b1;
    req = 0; we = 0; addr = 0; wdata = 0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ack", {31'd0, ack}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_ack0", {31'd0, ack0}, 32'd0);
    reset = 1'b0;

    // Store then load back.
    applyStimulus("st8", 1'b1, 32'h8, 32'hDEADBEEF);
    applyStimulus("ld8", 1'b0, 32'h8, 32'h0);

    // Misaligned load and store leave 0x4 intact.
    applyStimulus("st4", 1'b1, 32'h4, 32'h11112222);
    applyStimulus("ld6", 1'b0, 32'h6, 32'h0);
    applyStimulus("st5", 1'b1, 32'h5, 32'h99999999);
    applyStimulus("ld4", 1'b0, 32'h4, 32'h0);

    // Request while busy is ignored: exactly one ack, no write to 0x24.
    applyStimulus("st24", 1'b1, 32'h24, 32'h24242424);
    exp_q.push_back(model_access(1'b1, 32'h20, 32'h00000055));
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h00000055;
    @(posedge clk);
    @(negedge clk);
    addr = 32'h24; wdata = 32'h99999999;
    acks = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) begin req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; end
      if (ack) begin
        acks++;
        popCompare("busy_st20");
      end
      @(negedge clk);
    end
    checkOutput("busy_one_ack", acks, 32'd1);
    applyStimulus("ld24", 1'b0, 32'h24, 32'h0);
    applyStimulus("ld20", 1'b0, 32'h20, 32'h0);

    // Reset during WAIT aborts the store.
    applyStimulus("st10", 1'b1, 32'h10, 32'hAAAA5555);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
    checkOutput("abort_busy_wait", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      if (ack) acks++;
      @(negedge clk);
    end
    checkOutput("abort_no_ack", acks, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    applyStimulus("ld10", 1'b0, 32'h10, 32'h0);

    // Upper address bits: wrap, or error with the bounds check.
    applyStimulus("st0", 1'b1, 32'h0, 32'h0BADF00D);
    applyStimulus("st100", 1'b1, 32'h100, 32'hCAFEF00D);
    applyStimulus("ld0", 1'b0, 32'h0, 32'h0);

    // LATENCY=0 instance: store, load, then back-to-back requests.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h4; wdata0 = 32'h0F0F0F0F;
    @(posedge clk);
    @(negedge clk);
    req0 = 1'b0; we0 = 1'b0;
    checkOutput("l0_st_ack", {31'd0, ack0}, 32'd1);
    checkOutput("l0_st_err", {31'd0, err0}, 32'd0);
    checkOutput("l0_st_rdata", rdata0, 32'd0);
    @(negedge clk);
    checkOutput("l0_idle_ack", {31'd0, ack0}, 32'd0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h4;
    @(posedge clk);
    @(negedge clk);
    req0 = 1'b0;
    checkOutput("l0_ld_ack", {31'd0, ack0}, 32'd1);
    checkOutput("l0_ld_rdata", rdata0, 32'h0F0F0F0F);
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h4;
    acks = 0; prev_ack = 0; adjacent = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ack0) begin
        acks++;
        checkOutput("l0_b2b_rdata", rdata0, 32'h0F0F0F0F);
        if (prev_ack != 0) adjacent++;
      end
      prev_ack = int'(ack0);
    end
    req0 = 1'b0;
    checkOutput("l0_b2b_acks", acks, 32'd4);
    checkOutput("l0_b2b_adjacent", adjacent, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("l0_final_busy", {31'd0, busy0}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
